// File: rtl/dmem_mmio_unit_pkg.sv
// Shared definitions for the data-memory / MMIO unit: access-type codes,
// MMIO register offsets and the access-size helper.
package dmem_mmio_unit_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_HALFU = 3'b010,
    DM_BYTE  = 3'b011,
    DM_BYTEU = 3'b100
  } dm_type_e;

  localparam logic [7:0] DM_MMIO_LED      = 8'h00;
  localparam logic [7:0] DM_MMIO_SW       = 8'h04;
  localparam logic [7:0] DM_MMIO_CYCLE    = 8'h08;
  localparam logic [7:0] DM_MMIO_STORES   = 8'h0C;
  localparam logic [7:0] DM_MMIO_ERR      = 8'h10;
  localparam logic [7:0] DM_MMIO_ERR_ADDR = 8'h14;

  // log2 of the access size in bytes; unknown codes behave as word accesses
  function automatic logic [1:0] dm_size_log2(input logic [2:0] t);
    case (t)
      DM_HALF, DM_HALFU: dm_size_log2 = 2'd1;
      DM_BYTE, DM_BYTEU: dm_size_log2 = 2'd0;
      default:           dm_size_log2 = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_unit_if.sv
// MEM-stage data bus between the CPU (master) and the memory/MMIO unit (slave).
interface dmem_mmio_unit_if;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;

  modport master (output mem_w, addr, wdata, dm_type, input rdata);
  modport slave  (input mem_w, addr, wdata, dm_type, output rdata);
endinterface

// File: rtl/dmem_mmio_unit_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load extraction with sign/zero extension, and the misalignment flag.
module dm_lane_align
  import dmem_mmio_unit_pkg::*;
(
  input  logic [2:0]  i_dm_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlane,
  output logic [31:0] o_rdata,
  output logic        o_misal
);
  logic [1:0]  w_sz;
  logic        w_sign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sz   = dm_size_log2(i_dm_type);
  assign w_sign = (i_dm_type == DM_HALF) || (i_dm_type == DM_BYTE);
  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_misal = 1'b0;
    o_be    = 4'b1111;
    o_wlane = i_wdata;
    o_rdata = i_rword;
    case (w_sz)
      2'd0: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wlane = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_sign & w_byte[7]}}, w_byte};
      end
      2'd1: begin
        o_misal = i_addr_lo[0];
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wlane = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_sign & w_half[15]}}, w_half};
      end
      default: o_misal = |i_addr_lo;
    endcase
  end
endmodule

// File: rtl/dmem_mmio_unit.sv
// Data RAM plus MMIO register block (LED, switches, cycle/store counters,
// sticky error capture). Loads are combinational, stores commit on clk.
module dmem_mmio_unit
  import dmem_mmio_unit_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_mmio_unit_if.slave       bus,
  input  logic [15:0]           i_sw_in,
  output logic [15:0]           o_led_out,
  output logic                  o_err_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [15:0] r_led, r_sw1, r_sw2;
  logic [31:0] r_cycle, r_stores, r_err_addr;
  logic        r_err;

  logic [AW-1:0] w_idx;
  logic          w_ram_hit, w_mmio_hit, w_word, w_misal;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane, w_ext, w_mmio_rd;
  logic          w_store_err, w_ram_we, w_mmio_we, w_led_we, w_err_clr;

  assign w_idx      = bus.addr[AW+1:2];
  assign w_ram_hit  = bus.addr < 32'(DEPTH_WORDS * 4);
  assign w_mmio_hit = bus.addr[31:16] == MMIO_BASE[31:16];
  assign w_word     = dm_size_log2(bus.dm_type) == 2'd2;

  dm_lane_align u_align (
    .i_dm_type (bus.dm_type),
    .i_addr_lo (bus.addr[1:0]),
    .i_wdata   (bus.wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wlane   (w_wlane),
    .o_rdata   (w_ext),
    .o_misal   (w_misal)
  );

  assign w_store_err = bus.mem_w &&
                       (w_misal || !(w_ram_hit || w_mmio_hit) || (w_mmio_hit && !w_word));
  assign w_ram_we    = bus.mem_w && w_ram_hit && !w_misal;
  assign w_mmio_we   = bus.mem_w && w_mmio_hit && w_word && !w_misal;
  assign w_led_we    = w_mmio_we && (bus.addr[7:0] == DM_MMIO_LED);
  assign w_err_clr   = w_mmio_we && (bus.addr[7:0] == DM_MMIO_ERR) && bus.wdata[0];

  always_comb begin
    w_mmio_rd = '0;
    case (bus.addr[7:0])
      DM_MMIO_LED:      w_mmio_rd = {16'b0, r_led};
      DM_MMIO_SW:       w_mmio_rd = {16'b0, r_sw2};
      DM_MMIO_CYCLE:    w_mmio_rd = r_cycle;
      DM_MMIO_STORES:   w_mmio_rd = r_stores;
      DM_MMIO_ERR:      w_mmio_rd = {31'b0, r_err};
      DM_MMIO_ERR_ADDR: w_mmio_rd = r_err_addr;
      default:          w_mmio_rd = '0;
    endcase
  end

  always_comb begin
    bus.rdata = '0;
    if (!w_misal) begin
      if (w_ram_hit)                 bus.rdata = w_ext;
      else if (w_mmio_hit && w_word) bus.rdata = w_mmio_rd;
    end
  end

  // RAM is not reset; the rst gate drops a store that coincides with reset
  always_ff @(posedge clk) begin
    if (!rst && w_ram_we) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led      <= '0;
      r_sw1      <= '0;
      r_sw2      <= '0;
      r_cycle    <= '0;
      r_stores   <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_sw1   <= i_sw_in;
      r_sw2   <= r_sw1;
      r_cycle <= r_cycle + 32'd1;
      if (w_led_we) r_led <= bus.wdata[15:0];
      if ((w_ram_we || w_led_we) && (r_stores != '1)) r_stores <= r_stores + 32'd1;
      // an error in the same cycle as a clear keeps the flag set
      if (w_store_err) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= bus.addr;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_led_out = r_led;
  assign o_err_irq = r_err;
endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Directed bench for dmem_mmio_unit with a byte-addressed reference model
// compared against the DUT on every falling edge.
module tb_dmem_mmio_unit;
  bit          clk = 1'b0;
  bit          rst = 1'b0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        err_irq;

  dmem_mmio_unit_if bus();

  dmem_mmio_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_sw_in   (sw_in),
    .o_led_out (led_out),
    .o_err_irq (err_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_byte [int];
  logic [15:0] m_led    = '0;
  bit          m_err    = 1'b0;
  logic [31:0] m_eaddr  = '0;
  logic [31:0] m_cycle  = '0;
  logic [31:0] m_stores = '0;
  logic [15:0] m_sw1    = '0;
  logic [15:0] m_sw2    = '0;

  // directed literal expectation for the current cycle
  int          lit_sel = -1;
  logic [31:0] lit_exp = '0;
  string       lit_nm  = "";
  bit          run     = 1'b0;

  function automatic int acc_size(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic void exp_load(input logic [31:0] a, input logic [2:0] t,
                                   output logic [31:0] v, output bit known);
    int n;
    logic [31:0] raw;
    n = acc_size(t);
    v = '0;
    known = 1'b1;
    raw = '0;
    if ((a % 32'(n)) != 0) return;
    if (a < 32'd4096) begin
      for (int i = 0; i < n; i++) begin
        if (!m_byte.exists(int'(a) + i)) known = 1'b0;
        else raw = raw | (32'(m_byte[int'(a) + i]) << (8 * i));
      end
      if (t == 3'd1)      v = {{16{raw[15]}}, raw[15:0]};
      else if (t == 3'd3) v = {{24{raw[7]}}, raw[7:0]};
      else                v = raw;
    end else if (a[31:16] == 16'hFFFF && n == 4) begin
      case (a[7:0])
        8'h00:   v = {16'b0, m_led};
        8'h04:   v = {16'b0, m_sw2};
        8'h08:   v = m_cycle;
        8'h0C:   v = m_stores;
        8'h10:   v = {31'b0, m_err};
        8'h14:   v = m_eaddr;
        default: v = '0;
      endcase
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led = '0; m_err = 1'b0; m_eaddr = '0; m_cycle = '0;
      m_stores = '0; m_sw1 = '0; m_sw2 = '0;
    end else begin
      if (bus.mem_w) begin
        int n;
        logic [31:0] a;
        bit ram, mmio, bad;
        a    = bus.addr;
        n    = acc_size(bus.dm_type);
        ram  = a < 32'd4096;
        mmio = a[31:16] == 16'hFFFF;
        bad  = ((a % 32'(n)) != 0) || (!ram && !mmio) || (mmio && n != 4);
        if (bad) begin
          if (!m_err) m_eaddr = a;
          m_err = 1'b1;
        end else if (ram) begin
          for (int i = 0; i < n; i++) m_byte[int'(a) + i] = bus.wdata[8*i +: 8];
          if (m_stores != 32'hFFFF_FFFF) m_stores = m_stores + 1;
        end else begin
          if (a[7:0] == 8'h00) begin
            m_led = bus.wdata[15:0];
            if (m_stores != 32'hFFFF_FFFF) m_stores = m_stores + 1;
          end
          if (a[7:0] == 8'h10 && bus.wdata[0]) m_err = 1'b0;
        end
      end
      m_sw2   = m_sw1;
      m_sw1   = sw_in;
      m_cycle = m_cycle + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      logic [31:0] ev;
      bit kn;
      exp_load(bus.addr, bus.dm_type, ev, kn);
      if (kn) chk("rdata", bus.rdata, ev);
      chk("led_out", {16'b0, led_out}, {16'b0, m_led});
      chk("err_irq", {31'b0, err_irq}, {31'b0, m_err});
      case (lit_sel)
        0: chk(lit_nm, bus.rdata, lit_exp);
        1: chk(lit_nm, {16'b0, led_out}, lit_exp);
        2: chk(lit_nm, {31'b0, err_irq}, lit_exp);
        default: ;
      endcase
    end
  end

  task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] t, input int sel, input logic [31:0] ex,
                      input string nm);
    bus.mem_w   = mw;
    bus.addr    = a;
    bus.wdata   = wd;
    bus.dm_type = t;
    lit_sel     = sel;
    lit_exp     = ex;
    lit_nm      = nm;
    @(posedge clk);
    #1;
    lit_sel = -1;
  endtask

  localparam logic [31:0] LED = 32'hFFFF_0000, SW = 32'hFFFF_0004, CYC = 32'hFFFF_0008,
                          STR = 32'hFFFF_000C, ERR = 32'hFFFF_0010, EAD = 32'hFFFF_0014;

  initial begin
    bus.mem_w = 1'b0; bus.addr = CYC; bus.wdata = '0; bus.dm_type = 3'd0;
    rst = 1'b1;
    run = 1'b1;
    // reset state
    step(0, CYC, 0, 0, 0, 32'h0, "cycle_in_reset");
    step(0, STR, 0, 0, 0, 32'h0, "stores_in_reset");
    step(0, EAD, 0, 0, 1, 32'h0, "led_in_reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(0, CYC, 0, 0, -1, 0, "");
    step(0, CYC, 0, 0, 0, 32'd5, "cycle_after_5");
    // word store and extended loads
    step(1, 32'h10, 32'hDEADBEEF, 0, -1, 0, "");
    step(0, 32'h10, 0, 0, 0, 32'hDEADBEEF, "ld_word");
    step(0, 32'h13, 0, 3, 0, 32'hFFFFFFDE, "ld_byte_s");
    step(0, 32'h13, 0, 4, 0, 32'h000000DE, "ld_byte_u");
    step(0, 32'h12, 0, 2, 0, 32'h0000DEAD, "ld_half_u");
    // byte store into a zeroed word
    step(1, 32'h20, 32'h0, 0, -1, 0, "");
    step(1, 32'h21, 32'h000000A5, 3, -1, 0, "");
    step(0, 32'h20, 0, 0, 0, 32'h0000A500, "byte_lane_word");
    step(0, 32'h20, 0, 1, 0, 32'hFFFFA500, "byte_lane_half");
    // store and load same cycle returns old data
    step(1, 32'h10, 32'h11111111, 0, 0, 32'hDEADBEEF, "store_old_val");
    step(0, 32'h10, 0, 0, 0, 32'h11111111, "store_new_val");
    // error capture
    step(1, 32'h30, 32'hCAFEF00D, 0, -1, 0, "");
    step(1, 32'h31, 32'h0000FFFF, 1, -1, 0, "");
    step(0, 32'h30, 0, 0, 0, 32'hCAFEF00D, "misal_ram_kept");
    step(0, STR, 0, 0, 0, 32'd5, "stores_no_err");
    step(0, EAD, 0, 0, 0, 32'h31, "err_addr_first");
    step(0, ERR, 0, 0, 2, 32'h1, "err_irq_set");
    step(1, 32'h42, 32'h0, 0, -1, 0, "");
    step(0, EAD, 0, 0, 0, 32'h31, "err_addr_sticky");
    step(1, ERR, 32'h1, 0, -1, 0, "");
    step(0, ERR, 0, 0, 2, 32'h0, "err_cleared");
    // LED register
    step(1, LED, 32'h0001ABCD, 0, -1, 0, "");
    step(0, LED, 0, 0, 0, 32'h0000ABCD, "led_read");
    step(1, LED, 32'h00000077, 3, -1, 0, "");
    step(0, EAD, 0, 0, 1, 32'h0000ABCD, "led_byte_rejected");
    step(0, EAD, 0, 0, 0, LED, "err_addr_led");
    step(1, ERR, 32'h1, 0, -1, 0, "");
    step(1, 32'h0010_0000, 32'h5, 0, -1, 0, "");
    step(0, EAD, 0, 0, 0, 32'h0010_0000, "err_addr_unmapped");
    step(1, ERR, 32'h1, 0, -1, 0, "");
    step(1, 32'hFFFF_0020, 32'h9, 0, -1, 0, "");
    step(0, 32'hFFFF_0020, 0, 0, 0, 32'h0, "mmio_other_zero");
    step(0, ERR, 0, 0, 0, 32'h0, "mmio_other_no_err");
    // switch synchroniser latency
    sw_in = 16'h5A5A;
    step(0, SW, 0, 0, 0, 32'h0, "sw_lat0");
    step(0, SW, 0, 0, 0, 32'h0, "sw_lat1");
    step(0, SW, 0, 0, 0, 32'h00005A5A, "sw_visible");
    // reset in the middle of a store
    bus.mem_w = 1'b1; bus.addr = LED; bus.wdata = 32'h1234; bus.dm_type = 3'd0;
    #1 rst = 1'b1;
    lit_sel = 1; lit_exp = 32'h0; lit_nm = "led_async_reset";
    @(posedge clk);
    #1 rst = 1'b0;
    lit_sel = -1;
    step(0, STR, 0, 0, 0, 32'h0, "stores_after_reset");
    step(1, LED, 32'h0000000F, 0, -1, 0, "");
    step(0, STR, 0, 0, 1, 32'h0000000F, "led_after_reset");
    step(1, 32'h100, 32'h1, 0, -1, 0, "");
    step(1, 32'h104, 32'h2, 0, -1, 0, "");
    step(1, 32'h101, 32'h3, 1, -1, 0, "");
    step(0, STR, 0, 0, 0, 32'd3, "stores_3_good_1_bad");
    step(0, CYC, 0, 0, -1, 0, "");
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_unit.md
# dmem_mmio_unit

Data-memory and memory-mapped-I/O unit directly downstream of the pipelined CPU's MEM stage. Consumes the MEM-stage address, store data, write strobe and DMType, and returns load data in the same cycle. Stores commit on the clock edge. Contains the word-addressed data RAM, byte/halfword lane logic, sign/zero extension, and a small MMIO register block: LEDs, switches, cycle counter, store counter and error capture.

## Interface
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000: MMIO window base; window is MMIO_BASE[31:16] match, offset addr[7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_w  in  1  store strobe from MEM stage.
- addr  in  32  byte address (MEM-stage ALU result).
- wdata  in  32  store data (forwarded rs2), low-aligned.
- dm_type  in  3  access type: word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100.
- sw_in  in  16  board switches, asynchronous.
- rdata  out  32  load data, extended per dm_type.
- led_out  out  16  LED register.
- err_irq  out  1  sticky error flag (ERR[0]).

## Operation
- Decode: RAM if addr < DEPTH_WORDS*4 (index addr[log2(DEPTH_WORDS)+1:2]); MMIO if addr[31:16]==MMIO_BASE[31:16]; otherwise unmapped.
- Alignment: half requires addr[0]==0; word requires addr[1:0]==0; byte always aligned.
- RAM store: byte enables from dm_type/addr[1:0]; wdata[7:0] or wdata[15:0] replicated into the selected lane(s).
- RAM load: the selected byte/half is shifted to bit 0; 001/011 sign-extend, 010/100 zero-extend, 000 passes the full word.
- Load data for unmapped addresses or misaligned loads: 0. No error is raised for loads, because the CPU presents an address every cycle.
- MMIO registers are word-only. A non-word MMIO store is an error.
- LED, offset 0x00: RW. Bits [15:0] are used; read-back is zero-extended.
- SW, offset 0x04: RO. sw_in passed through a 2-flop synchroniser.
- CYCLE, offset 0x08: RO. Free-running, +1 every cycle, wraps at 2^32.
- STORES, offset 0x0C: RO. +1 per committed store (RAM or LED); saturates at FFFF_FFFF.
- ERR, offset 0x10: bit0 sticky. A write with wdata[0]=1 clears it; other writes are ignored.
- ERR_ADDR, offset 0x14: RO. Address of the first error since the last clear.
- Any other MMIO offset reads 0, and stores to it are silently dropped (no error).
- Store error conditions: misaligned, unmapped, or non-word MMIO.
- On a store error: the store is dropped and not counted; ERR[0] is set. ERR_ADDR loads addr only if ERR[0] was 0.
- If an error and an ERR clear occur in the same cycle, the error wins.

## Timing
- Loads are combinational: rdata is valid in the same cycle as addr/dm_type.
- Stores commit at the rising clk edge while mem_w=1 and are visible to a load in the next cycle.
- A load in the same cycle as a store to the same location returns the old value.
- CYCLE reads the pre-increment value.
- SW latency is 2 cycles from a sw_in change to its visibility in rdata.
- Reset (asynchronous, takes effect immediately, including mid-store):
  - led_out=0, err_irq=0, ERR_ADDR=0, CYCLE=0, STORES=0, synchroniser flops 0.
  - A store coincident with reset is lost.
  - RAM contents are not reset; they are optionally initialised by $readmemh at elaboration.
- rdata has no reset value of its own; it follows addr combinationally.

## Structure
- The shared package, ctrl_encode_def.v, gains:
  - the dm_type codes (reused from the existing DMType defines);
  - MMIO offset constants DM_MMIO_LED/SW/CYCLE/STORES/ERR/ERR_ADDR.
- One natural sub-module, dm_lane_align, is purely combinational. It produces the byte enables and write-lane data, the read extraction and extension, and the misalignment flag.
- The top contains the RAM array, address decode, MMIO registers and counters.

## Test plan
- Store word 32'hDEADBEEF @0x10; next cycle load: type 000 → DEADBEEF; 011 @0x13 → FFFFFFDE; 100 @0x13 → 000000DE; 010 @0x12 → 0000DEAD.
- Store byte wdata=32'h000000A5 @0x21 over word 0 → word @0x20 reads 0000A500; half 001 @0x20 → FFFFA500.
- Misaligned half store @0x31 → RAM unchanged, err_irq=1, ERR_ADDR=0x31, STORES unchanged; later misaligned word @0x42 → ERR_ADDR stays 0x31; store 1 to ERR → err_irq=0.
- Store 32'h0001_ABCD to LED → led_out=ABCD next cycle; read LED → 0000ABCD; byte store to LED → error, LED unchanged.
- Drive sw_in=16'h5A5A → SW reads 0 for 2 cycles, then 00005A5A; after rst, read CYCLE at clock N → N; STORES after 3 good and 1 bad stores → 3.
- Assert rst in the same cycle as a store of 0x1234 to LED → led_out=0 immediately, STORES=0; deassert and store 0x0F → led_out=000F.
